dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the core's single-port data memory between the pipeline MEM stage and an external requester (debug/program loader/DMA).
- The core has priority. The external port is served on idle MEM-stage cycles.
- A starvation counter forces a one-cycle core stall to guarantee external progress.
- Sits between the EX/MEM register outputs and data_mem; core_stall feeds the hazard unit.

Parameters:
- STARVE_LIMIT, 4: consecutive blocked external cycles before a forced grant; legal range 1..255.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- core_we  in  1  MEM-stage store (MemWriteM)
- core_re  in  1  MEM-stage load (ResultSrcM==01)
- core_addr  in  AW  MEM-stage address (ALUResultM)
- core_wdata  in  DW  store data (RD2M)
- core_rdata  out  DW  load data to MEM/WB
- core_stall  out  1  freeze IF..MEM this cycle
- ext_valid  in  1  external request valid
- ext_ready  out  1  external request accepted this cycle
- ext_we  in  1  1=write, 0=read
- ext_addr  in  AW  external address
- ext_wdata  in  DW  external write data
- ext_rvalid  out  1  external read data valid (one-cycle pulse)
- ext_rdata  out  DW  external read data
- mem_we  out  1  to data_mem we
- mem_addr  out  AW  to data_mem A
- mem_wdata  out  DW  to data_mem WD
- mem_rdata  in  DW  from data_mem ReadData (combinational read)
- grant_ext  out  1  memory owned by external port this cycle

Behaviour:
- core_active = core_we | core_re.
- FSM states:
  - S_NORMAL (reset state).
  - S_FORCE.
- S_NORMAL:
  - core_stall=0.
  - If core_active: memory driven by core.
  - Else if ext_valid: grant_ext=1 and ext_ready=1, memory driven by ext.
  - Else: mem_we=0, mem_addr/mem_wdata=core values.
- S_FORCE:
  - core_stall=1, grant_ext=1, ext_ready=ext_valid.
  - Memory driven by ext; core inputs ignored.
  - Unconditionally returns to S_NORMAL next cycle.
  - If ext_valid is 0 in S_FORCE (protocol violation), mem_we=0 and no response is generated.
- Wait counter wcnt, width $clog2(STARVE_LIMIT+1):
  - Cleared when ext_valid=0, on any ext handshake, and in S_FORCE.
  - Increments when ext_valid & ~ext_ready in S_NORMAL.
  - Never exceeds STARVE_LIMIT.
  - When the increment makes wcnt==STARVE_LIMIT: next state S_FORCE.
- Handshake:
  - Transfer occurs on ext_valid & ext_ready.
  - External must hold ext_valid/ext_we/ext_addr/ext_wdata stable until ready.
  - ext_ready is combinational, with no dependency on ext_we/addr/wdata.
- Write: mem_we=ext_we in the grant cycle; data_mem commits at that edge.
- Read:
  - mem_rdata captured into ext_rdata at the grant edge.
  - ext_rvalid=1 for exactly the following cycle.
  - Latency from handshake to data is 1 cycle.
  - ext_rdata holds its value until the next ext read.
  - Ext write handshakes do not pulse ext_rvalid.
- core_rdata = mem_rdata, combinational, valid when the core owns memory. Its value is don't-care in grant_ext cycles; the pipeline is either idle or stalled then.
- mem_we is never asserted for both requesters in one cycle. At most one owner per cycle.
- Back-to-back ext requests:
  - Allowed every cycle while core idle (ready can be high consecutive cycles).
  - ext_rvalid may then be high consecutive cycles, with pipelined data.
- Reset asserted mid-operation, asynchronously:
  - state=S_NORMAL, wcnt=0.
  - ext_rvalid=0, ext_rdata=0.
  - core_stall=0 and grant_ext=0 immediately.
  - A pending read response is dropped.
- Reset values of outputs: core_stall=0, ext_ready=0, ext_rvalid=0, ext_rdata=0, grant_ext=0, mem_we=0. mem_addr, mem_wdata and core_rdata follow their inputs.

Test Plan:
1. Core idle, ext write addr 0x40 data 0xDEADBEEF, then ext read 0x40:
   - ext_ready high same cycle each time, mem_we=1 on the write.
   - ext_rvalid pulses 1 cycle after the read handshake with ext_rdata=0xDEADBEEF.
   - core_stall never asserts.
2. Core load every cycle, ext read pending, STARVE_LIMIT=4:
   - ext_ready low 4 cycles, then S_FORCE: core_stall=1, grant_ext=1, ext_ready=1.
   - Next cycle core_stall=0 and wcnt=0.
3. Core store 0x11 to 0x80 and ext write 0x22 to 0x80 in the same cycle (core active):
   - Core wins; mem holds 0x11.
   - Ext is granted on the first core-idle cycle; final mem[0x80]=0x22.
4. Ext valid asserted 2 cycles while core busy, then deasserted:
   - wcnt returns to 0.
   - A new request must wait a full 4 cycles before force.
5. Reset driven low during an S_FORCE cycle with a read in flight:
   - core_stall and grant_ext drop immediately; ext_rvalid stays 0.
   - After release, the FSM is in S_NORMAL with wcnt=0.
6. Core idle, 3 back-to-back ext reads of 0x0, 0x4, 0x8:
   - ext_ready high 3 consecutive cycles.
   - ext_rvalid high 3 consecutive cycles, data in address order.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data memory arbiter: shares the single-port data memory between the
// pipeline MEM stage (priority) and an external requester. The external
// port uses idle MEM-stage cycles. If it is blocked for STARVE_LIMIT cycles
// in a row, the core is stalled for one cycle and the external port is served.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_NORMAL | core owns memory when active, ext served on idle cycles
// S_FORCE  | one-cycle forced ext grant, core stalled
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_we,
    input  logic          core_re,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          ext_valid,
    output logic          ext_ready,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          grant_ext
);

    localparam int WCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WCW-1:0] LIMIT = WCW'(STARVE_LIMIT);

    localparam logic [0:0] S_NORMAL = 1'b0;
    localparam logic [0:0] S_FORCE  = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           rvalid_q, rvalid_d;
    logic [DW-1:0]  rdata_q, rdata_d;

    logic           core_active;
    logic           in_force;
    logic           handshake;
    logic [WCW-1:0] wcnt_inc;

    assign core_active = core_we | core_re;
    assign in_force    = (state_q == S_FORCE);
    assign wcnt_inc    = wcnt_q + WCW'(1);

    // Ownership and memory port steering; grants are masked while reset is
    // held so nothing reaches the memory before the FSM is running.
    always_comb begin
        grant_ext  = 1'b0;
        ext_ready  = 1'b0;
        core_stall = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        if (in_force) begin
            core_stall = 1'b1;
            grant_ext  = 1'b1;
            ext_ready  = ext_valid;
        end else if (!core_active && ext_valid) begin
            grant_ext  = 1'b1;
            ext_ready  = 1'b1;
        end
        if (!reset) begin
            grant_ext  = 1'b0;
            ext_ready  = 1'b0;
            core_stall = 1'b0;
        end
        if (grant_ext) begin
            // A forced grant without a valid request must not write.
            mem_we    = ext_we & ext_valid;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end else if (core_active && reset) begin
            mem_we    = core_we;
        end
    end

    assign handshake  = ext_valid & ext_ready;
    assign core_rdata = mem_rdata;
    assign ext_rvalid = rvalid_q;
    assign ext_rdata  = rdata_q;

    // Starvation counter, FSM next state and read response capture.
    always_comb begin
        state_d  = S_NORMAL;
        wcnt_d   = wcnt_q;
        rvalid_d = handshake & ~ext_we;
        rdata_d  = rdata_q;
        if (in_force || !ext_valid || handshake) begin
            wcnt_d = '0;
        end else if (wcnt_q < LIMIT) begin
            wcnt_d = wcnt_inc;
            if (wcnt_inc == LIMIT) begin
                state_d = S_FORCE;
            end
        end
        if (handshake && !ext_we) begin
            rdata_d = mem_rdata;
        end
    end

    // State registers; async reset drops any in-flight read response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_NORMAL;
            wcnt_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed data memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_we, core_re;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_stall;
    logic        ext_valid, ext_ready, ext_we;
    logic [31:0] ext_addr, ext_wdata;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        grant_ext;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];
    logic        preloaded = 1'b0;

    dmem_arbiter #(.STARVE_LIMIT(4), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_we    (core_we),
        .core_re    (core_re),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .ext_valid  (ext_valid),
        .ext_ready  (ext_ready),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .grant_ext  (grant_ext)
    );

    always #5 clk = ~clk;

    // data memory model: combinational read, write at rising edge
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (!preloaded) begin
            mem[0]    <= 32'h0000_00A0;
            mem[1]    <= 32'h0000_00A1;
            mem[2]    <= 32'h0000_00A2;
            mem[8'h11] <= 32'h5A5A_1234;
            mem[8'h12] <= 32'hCAFE_F00D;
            preloaded <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b0;
        core_we = 0; core_re = 0; core_addr = 32'h100; core_wdata = 0;
        ext_valid = 1; ext_we = 1; ext_addr = 32'h40; ext_wdata = 0;
        #2;
        // reset state, with ext_valid asserted to exercise output masking
        chk("rst_ready",  {31'b0, ext_ready},  0);
        chk("rst_grant",  {31'b0, grant_ext},  0);
        chk("rst_stall",  {31'b0, core_stall}, 0);
        chk("rst_rvalid", {31'b0, ext_rvalid}, 0);
        chk("rst_rdata",  ext_rdata,           0);
        chk("rst_memwe",  {31'b0, mem_we},     0);
        tick(); tick();
        ext_valid = 0;
        reset = 1'b1;
        tick();

        // 1: core idle, ext write then ext read of 0x40
        ext_valid = 1; ext_we = 1; ext_addr = 32'h40; ext_wdata = 32'hDEADBEEF;
        settle();
        chk("t1_wr_ready", {31'b0, ext_ready},  1);
        chk("t1_wr_memwe", {31'b0, mem_we},     1);
        chk("t1_wr_grant", {31'b0, grant_ext},  1);
        chk("t1_wr_stall", {31'b0, core_stall}, 0);
        tick();
        ext_we = 0;
        settle();
        chk("t1_rd_ready",  {31'b0, ext_ready},  1);
        chk("t1_rd_memwe",  {31'b0, mem_we},     0);
        chk("t1_wr_norv",   {31'b0, ext_rvalid}, 0);
        tick();
        ext_valid = 0;
        settle();
        chk("t1_rvalid",  {31'b0, ext_rvalid}, 1);
        chk("t1_rdata",   ext_rdata,           32'hDEADBEEF);
        chk("t1_stall",   {31'b0, core_stall}, 0);
        tick();
        chk("t1_rv_off",  {31'b0, ext_rvalid}, 0);
        chk("t1_rdhold",  ext_rdata,           32'hDEADBEEF);

        // 2: core loads every cycle, ext read starves until forced
        core_re = 1; core_addr = 32'h100;
        ext_valid = 1; ext_we = 0; ext_addr = 32'h44;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t2_blk_ready", {31'b0, ext_ready},  0);
            chk("t2_blk_stall", {31'b0, core_stall}, 0);
            chk("t2_blk_addr",  mem_addr,            32'h100);
            tick();
        end
        chk("t2_f_stall", {31'b0, core_stall}, 1);
        chk("t2_f_grant", {31'b0, grant_ext},  1);
        chk("t2_f_ready", {31'b0, ext_ready},  1);
        chk("t2_f_addr",  mem_addr,            32'h44);
        tick();
        ext_valid = 0;
        settle();
        chk("t2_post_stall", {31'b0, core_stall}, 0);
        chk("t2_post_wcnt",  32'(dut.wcnt_q),     0);
        chk("t2_rvalid",     {31'b0, ext_rvalid}, 1);
        chk("t2_rdata",      ext_rdata,           32'h5A5A1234);
        tick();

        // 3: core store and ext write to 0x80 in the same cycle
        core_re = 0; core_we = 1; core_addr = 32'h80; core_wdata = 32'h11;
        ext_valid = 1; ext_we = 1; ext_addr = 32'h80; ext_wdata = 32'h22;
        settle();
        chk("t3_core_wd",  mem_wdata,           32'h11);
        chk("t3_core_we",  {31'b0, mem_we},     1);
        chk("t3_ext_wait", {31'b0, ext_ready},  0);
        tick();
        core_we = 0;
        settle();
        chk("t3_mem_core", mem[8'h20],          32'h11);
        chk("t3_ext_rdy",  {31'b0, ext_ready},  1);
        chk("t3_ext_wd",   mem_wdata,           32'h22);
        tick();
        ext_valid = 0;
        settle();
        chk("t3_mem_ext",  mem[8'h20],          32'h22);
        tick();

        // 4: two blocked cycles then withdraw; new request waits full 4
        core_re = 1; core_addr = 32'h100;
        ext_valid = 1; ext_we = 0; ext_addr = 32'h48;
        tick(); tick();
        chk("t4_wcnt2", 32'(dut.wcnt_q), 2);
        ext_valid = 0;
        tick();
        chk("t4_wcnt0", 32'(dut.wcnt_q), 0);
        ext_valid = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t4_blk_stall", {31'b0, core_stall}, 0);
            chk("t4_blk_ready", {31'b0, ext_ready},  0);
            tick();
        end
        chk("t4_f_stall", {31'b0, core_stall}, 1);

        // 5: reset asserted during the forced read cycle
        reset = 1'b0;
        settle();
        chk("t5_stall_drop", {31'b0, core_stall}, 0);
        chk("t5_grant_drop", {31'b0, grant_ext},  0);
        chk("t5_ready_drop", {31'b0, ext_ready},  0);
        tick();
        chk("t5_rv_in_rst",  {31'b0, ext_rvalid}, 0);
        ext_valid = 0; core_re = 0;
        reset = 1'b1;
        settle();
        chk("t5_state",  32'(dut.state_q),     0);
        chk("t5_wcnt",   32'(dut.wcnt_q),      0);
        chk("t5_rvalid", {31'b0, ext_rvalid},  0);
        chk("t5_rdata",  ext_rdata,            0);
        tick();
        chk("t5_rv_after", {31'b0, ext_rvalid}, 0);

        // 6: three back-to-back ext reads with core idle
        ext_valid = 1; ext_we = 0; ext_addr = 32'h0;
        settle();
        chk("t6_rdy0", {31'b0, ext_ready},  1);
        chk("t6_rv0",  {31'b0, ext_rvalid}, 0);
        tick();
        ext_addr = 32'h4;
        settle();
        chk("t6_rdy1", {31'b0, ext_ready},  1);
        chk("t6_rv1",  {31'b0, ext_rvalid}, 1);
        chk("t6_d0",   ext_rdata,           32'hA0);
        tick();
        ext_addr = 32'h8;
        settle();
        chk("t6_rdy2", {31'b0, ext_ready},  1);
        chk("t6_rv2",  {31'b0, ext_rvalid}, 1);
        chk("t6_d1",   ext_rdata,           32'hA1);
        tick();
        ext_valid = 0;
        settle();
        chk("t6_rv3",  {31'b0, ext_rvalid}, 1);
        chk("t6_d2",   ext_rdata,           32'hA2);
        tick();
        chk("t6_rvoff", {31'b0, ext_rvalid}, 0);
        chk("t6_stall", {31'b0, core_stall}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
